alu_share_ctrl: RTL

Round-robin controller that shares the single 4-bit ALU (add/sub/and/or, op codes 00/01/10/11) between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU from registered operands. It captures the ALU result and returns it to the requester with its id and a zero flag, holding the response under backpressure. It sits between the requesting units and the combinational ALU; the ALU itself is unchanged.

---
 rtl/alu_share_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational 4-bit ALU between two requesters.
// One operation is in flight at a time: accept (IDLE), drive the ALU from
// registered operands (EXEC), then hold the captured result until the
// consumer takes it (RESP). Contended arbitration is round robin.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/ready  per-requester handshake (ready is combinational)
//   req{0,1}_a/_b/_op     per-requester operands and op code
//   alu_a/alu_b/alu_op    registered operands presented to the ALU
//   alu_result            combinational ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/result/zero    issuing requester, captured result, result==0 flag
module alu_share_ctrl #(
    parameter bit FIRST_PRIO = 1'b0,
    localparam int unsigned DATA_W = 4,
    localparam int unsigned OP_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last;       // requester granted most recently
    logic   op_id;      // requester owning the in-flight operation

    logic   any_valid_c;
    logic   grant_id_c;
    logic   accept_c;

    // Arbitration: a lone requester wins outright; contention goes to the one not served last.
    always_comb begin
        any_valid_c = req0_valid | req1_valid;
        grant_id_c  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id_c = ~last;
        end else if (req1_valid) begin
            grant_id_c = 1'b1;
        end
    end

    // Ready is suppressed during reset so nothing is handshaken on a resetting edge.
    assign accept_c   = !reset && (state == IDLE) && any_valid_c;
    assign req0_ready = accept_c && !grant_id_c;
    assign req1_ready = accept_c &&  grant_id_c;

    // Controller FSM with registered ALU operands and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last       <= ~FIRST_PRIO;
            op_id      <= 1'b0;
            alu_a      <= DATA_W'(0);
            alu_b      <= DATA_W'(0);
            alu_op     <= OP_W'(0);
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= DATA_W'(0);
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid_c) begin
                        // Operands only change here, keeping ALU inputs quiet otherwise.
                        alu_a  <= grant_id_c ? req1_a  : req0_a;
                        alu_b  <= grant_id_c ? req1_b  : req0_b;
                        alu_op <= grant_id_c ? req1_op : req0_op;
                        op_id  <= grant_id_c;
                        last   <= grant_id_c;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= (alu_result == DATA_W'(0));
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
